// File: rtl/peak_finder_pkg.sv
// Shared types and defaults for the coarse-histogram peak finder.
// Defaults mirror the Nb / PIXEL_NUM_PER_RAM / count-width settings of the histogram subsystem.
package peak_finder_pkg;

  localparam int PF_NB        = 8;
  localparam int PF_CNT_W     = 16;
  localparam int PF_PIXEL_NUM = 4;
  localparam int PF_MIN_COUNT = 1;

  typedef enum logic [2:0] {
    PF_IDLE,
    PF_READ,
    PF_DRAIN,
    PF_EMIT,
    PF_FINISH
  } pf_state_e;

  // A single-pixel RAM still needs a 1-bit pixel select.
  function automatic int pf_pix_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/peak_finder_if.sv
// Histogram RAM read port plus peak result bus between the peak finder and its neighbours.
// master = peak finder, slave = RAM / threshold side.
interface peak_finder_if #(
  parameter int NB    = 8,
  parameter int CNT_W = 16,
  parameter int PIX_W = 2
);
  logic             start;
  logic             rd_en;
  logic [PIX_W-1:0] rd_pixel;
  logic [NB-1:0]    rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic [NB-1:0]    peakCH;
  logic [CNT_W-1:0] peakCount;
  logic [PIX_W-1:0] peakPixel;
  logic             peakValid;
  logic             peakDone;
  logic             frameDone;
  logic             busy;

  modport master (
    input  start, rd_data,
    output rd_en, rd_pixel, rd_addr,
    output peakCH, peakCount, peakPixel, peakValid, peakDone, frameDone, busy
  );

  modport slave (
    output start, rd_data,
    input  rd_en, rd_pixel, rd_addr,
    input  peakCH, peakCount, peakPixel, peakValid, peakDone, frameDone, busy
  );
endinterface

// File: rtl/peak_finder_max_tracker.sv
// Running maximum of a qualified data stream; strict compare so ties keep the earliest (lowest) index.
// Exposes the post-edge value so the caller can capture the result on the same edge as the last compare.
module peak_finder_max_tracker #(
  parameter int NB    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [CNT_W-1:0] data_i,
  input  logic [NB-1:0]    idx_i,
  output logic [CNT_W-1:0] max_nxt_o,
  output logic [NB-1:0]    idx_nxt_o
);

  logic [CNT_W-1:0] max_q, max_d;
  logic [NB-1:0]    idx_q, idx_d;

  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    if (clear_i) begin
      max_d = '0;
      idx_d = '0;
    end else if (valid_i && (data_i > max_q)) begin
      max_d = data_i;
      idx_d = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

  assign max_nxt_o = max_d;
  assign idx_nxt_o = idx_d;

endmodule

// File: rtl/peak_finder.sv
// Scans every bin of each pixel's coarse histogram and reports the highest-count bin per pixel.
// Peak registers load on the DRAIN->EMIT edge so peakDone lands (p+1)*(BIN_NUM+2) cycles after start.
module peak_finder
  import peak_finder_pkg::*;
#(
  parameter int NB        = PF_NB,
  parameter int CNT_W     = PF_CNT_W,
  parameter int PIXEL_NUM = PF_PIXEL_NUM,
  parameter int MIN_COUNT = PF_MIN_COUNT
) (
  input  logic          clk,
  input  logic          res,
  peak_finder_if.master bus
);

  localparam int               PIX_W    = pf_pix_w(PIXEL_NUM);
  localparam logic [NB-1:0]    LAST_BIN = '1;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM - 1);
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_COUNT);

  pf_state_e        state_q, state_d;
  logic [NB-1:0]    addr_q, addr_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;

  // rd_data is valid one cycle after rd_en; these qualify and tag it.
  logic             vld_q;
  logic [NB-1:0]    addr_dly_q;

  logic             rd_en, clear, emit_load, frame_load;
  logic [CNT_W-1:0] max_nxt;
  logic [NB-1:0]    idx_nxt;

  logic [NB-1:0]    peak_ch_q;
  logic [CNT_W-1:0] peak_cnt_q;
  logic [PIX_W-1:0] peak_pix_q;
  logic             peak_vld_q, peak_done_q, frame_done_q;

  // State register
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= PF_IDLE;
      addr_q  <= '0;
      pixel_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pixel_q <= pixel_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pixel_d = pixel_q;
    case (state_q)
      PF_IDLE: if (bus.start) begin
        state_d = PF_READ;
        addr_d  = '0;
        pixel_d = '0;
      end
      PF_READ: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_BIN) begin
          state_d = PF_DRAIN;
          addr_d  = '0;
        end
      end
      PF_DRAIN: state_d = PF_EMIT;
      PF_EMIT: begin
        if (pixel_q == LAST_PIX) begin
          state_d = PF_FINISH;
        end else begin
          state_d = PF_READ;
          pixel_d = pixel_q + 1'b1;
          addr_d  = '0;
        end
      end
      PF_FINISH: state_d = PF_IDLE;
      default:   state_d = PF_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    rd_en        = (state_q == PF_READ);
    bus.rd_en    = rd_en;
    bus.rd_addr  = rd_en ? addr_q  : '0;
    bus.rd_pixel = rd_en ? pixel_q : '0;
    bus.busy     = (state_q != PF_IDLE);
    clear        = ((state_q == PF_IDLE) && bus.start) || (state_q == PF_EMIT);
    emit_load    = (state_q == PF_DRAIN);
    frame_load   = (state_q == PF_EMIT) && (pixel_q == LAST_PIX);
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      vld_q      <= 1'b0;
      addr_dly_q <= '0;
    end else begin
      vld_q      <= rd_en;
      addr_dly_q <= addr_q;
    end
  end

  peak_finder_max_tracker #(
    .NB    (NB),
    .CNT_W (CNT_W)
  ) u_max (
    .clk       (clk),
    .res       (res),
    .clear_i   (clear),
    .valid_i   (vld_q),
    .data_i    (bus.rd_data),
    .idx_i     (addr_dly_q),
    .max_nxt_o (max_nxt),
    .idx_nxt_o (idx_nxt)
  );

  // Peak outputs hold until the next pixel's result is captured.
  always_ff @(posedge clk) begin
    if (!res) begin
      peak_ch_q    <= '0;
      peak_cnt_q   <= '0;
      peak_pix_q   <= '0;
      peak_vld_q   <= 1'b0;
      peak_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      peak_done_q  <= emit_load;
      frame_done_q <= frame_load;
      if (emit_load) begin
        peak_ch_q  <= idx_nxt;
        peak_cnt_q <= max_nxt;
        peak_pix_q <= pixel_q;
        peak_vld_q <= (max_nxt >= MIN_CNT);
      end
    end
  end

  assign bus.peakCH    = peak_ch_q;
  assign bus.peakCount = peak_cnt_q;
  assign bus.peakPixel = peak_pix_q;
  assign bus.peakValid = peak_vld_q;
  assign bus.peakDone  = peak_done_q;
  assign bus.frameDone = frame_done_q;

endmodule

// File: tb/tb_peak_finder.sv
// Directed bench for peak_finder: per-pixel histogram table, strobe timing, held start, mid-scan reset.
module tb_peak_finder;

  localparam int NB        = 8;
  localparam int CNT_W     = 16;
  localparam int PIXEL_NUM = 4;
  localparam int PIX_W     = 2;
  localparam int BIN_NUM   = 256;
  localparam int PER       = BIN_NUM + 2;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  peak_finder_if #(.NB(NB), .CNT_W(CNT_W), .PIX_W(PIX_W)) bus ();

  peak_finder #(
    .NB        (NB),
    .CNT_W     (CNT_W),
    .PIXEL_NUM (PIXEL_NUM),
    .MIN_COUNT (1)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // Histogram RAM model: one-cycle read latency.
  logic [CNT_W-1:0] mem [PIXEL_NUM][BIN_NUM];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_pixel][bus.rd_addr];

  typedef struct {
    int bin_a;
    int cnt_a;
    int bin_b;
    int cnt_b;
    bit noise;
    int exp_ch;
    int exp_cnt;
    int exp_valid;
  } vec_t;

  vec_t vecs [8];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Noise background is (b*7)%11, never above 10.
  task automatic load(input int base);
    for (int p = 0; p < PIXEL_NUM; p++) begin
      for (int b = 0; b < BIN_NUM; b++) begin
        int v;
        v = vecs[base+p].noise ? (b * 7) % 11 : 0;
        if (b == vecs[base+p].bin_a) v = vecs[base+p].cnt_a;
        if (b == vecs[base+p].bin_b) v = vecs[base+p].cnt_b;
        mem[p][b] = CNT_W'(v);
      end
    end
  endtask

  task automatic run_frame(input int base, input bit hold);
    int k;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 if (!hold) bus.start = 1'b0;
    @(negedge clk) k = 1;
    chk("first_rd_en", bus.rd_en, 1);
    chk("first_rd_addr", bus.rd_addr, 0);
    chk("first_rd_pixel", bus.rd_pixel, 0);
    chk("busy_scan", bus.busy, 1);
    for (int p = 0; p < PIXEL_NUM; p++) begin
      while (!bus.peakDone && k < PER * (p + 1) + 40) begin
        @(negedge clk) k++;
      end
      chk("peakDone_cycle", k, PER * (p + 1));
      chk("peakCH", bus.peakCH, vecs[base+p].exp_ch);
      chk("peakCount", bus.peakCount, vecs[base+p].exp_cnt);
      chk("peakValid", bus.peakValid, vecs[base+p].exp_valid);
      chk("peakPixel", bus.peakPixel, p);
      if (hold && p == PIXEL_NUM - 1) bus.start = 1'b0;
      @(negedge clk) k++;
      chk("peakDone_width", bus.peakDone, 0);
      chk("frameDone_timing", bus.frameDone, (p == PIXEL_NUM - 1) ? 1 : 0);
      chk("peakCH_hold", bus.peakCH, vecs[base+p].exp_ch);
    end
    @(negedge clk);
    chk("frameDone_width", bus.frameDone, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    vecs[0] = '{37, 200, -1, 0, 1'b1, 37, 200, 1};
    vecs[1] = '{5, 50, 9, 50, 1'b0, 5, 50, 1};
    vecs[2] = '{-1, 0, -1, 0, 1'b0, 0, 0, 0};
    vecs[3] = '{255, 65535, -1, 0, 1'b0, 255, 65535, 1};
    vecs[4] = '{3, 1000, -1, 0, 1'b1, 3, 1000, 1};
    vecs[5] = '{100, 500, 200, 499, 1'b0, 100, 500, 1};
    vecs[6] = '{200, 65535, 254, 65534, 1'b0, 200, 65535, 1};
    vecs[7] = '{254, 1, -1, 0, 1'b0, 254, 1, 1};

    bus.start = 1'b0;
    res       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_peakDone", bus.peakDone, 0);
    chk("rst_frameDone", bus.frameDone, 0);
    chk("rst_peakCH", bus.peakCH, 0);
    chk("rst_peakCount", bus.peakCount, 0);
    res = 1'b1;

    load(0);
    run_frame(0, 1'b0);
    load(4);
    run_frame(4, 1'b1);

    // Abort a scan during pixel 1, then rescan with different data.
    begin
      int k;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      k = 0;
      while (!(bus.rd_en && bus.rd_pixel == 1) && k < 2 * PER) begin
        @(negedge clk) k++;
      end
      chk("reached_pixel1", bus.rd_pixel, 1);
      repeat (50) @(negedge clk);
      chk("pre_rst_peakCount", bus.peakCount, 1000);
      res = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_rd_en", bus.rd_en, 0);
      chk("mid_rst_rd_addr", bus.rd_addr, 0);
      chk("mid_rst_rd_pixel", bus.rd_pixel, 0);
      chk("mid_rst_peakCH", bus.peakCH, 0);
      chk("mid_rst_peakCount", bus.peakCount, 0);
      chk("mid_rst_peakPixel", bus.peakPixel, 0);
      chk("mid_rst_peakValid", bus.peakValid, 0);
      chk("mid_rst_peakDone", bus.peakDone, 0);
      chk("mid_rst_frameDone", bus.frameDone, 0);
      @(negedge clk) res = 1'b1;
    end

    load(0);
    run_frame(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
